// File: rtl/fixed_pkg.sv
// Shared types and mode constants for the weight-stationary fixed-point PE.
package fixed_pkg;

  localparam int SAT_WRAP  = 0;
  localparam int SAT_CLAMP = 1;

  // Bank entries are stored at this width, already extended per their signed flag.
  localparam int WT_W_MAX = 8;

  typedef struct packed {
    logic                s;
    logic [WT_W_MAX-1:0] w;
  } wt_entry_t;

endpackage

// File: rtl/fixed_pe_ws_if.sv
// Activation / partial-sum / weight-load bundle between a PE and its driver.
interface fixed_pe_ws_if #(
  parameter int IN_W      = 8,
  parameter int WT_W      = 2,
  parameter int COL_WIDTH = 11,
  parameter int NUM_WT    = 4
);
  localparam int AW = $clog2(NUM_WT);

  logic                 in_valid;
  logic [IN_W-1:0]      in;
  logic                 s_in;
  logic [COL_WIDTH-1:0] psum_in;
  logic                 wt_load;
  logic [AW-1:0]        wt_addr;
  logic [WT_W-1:0]      wt_data;
  logic                 s_weight;
  logic [AW-1:0]        wt_sel;
  logic [IN_W-1:0]      in_fwd;
  logic                 s_in_fwd;
  logic                 in_valid_fwd;
  logic [COL_WIDTH-1:0] psum_fwd;
  logic                 psum_valid;

  modport master (
    output in_valid, in, s_in, psum_in, wt_load, wt_addr, wt_data, s_weight, wt_sel,
    input  in_fwd, s_in_fwd, in_valid_fwd, psum_fwd, psum_valid
  );

  modport slave (
    input  in_valid, in, s_in, psum_in, wt_load, wt_addr, wt_data, s_weight, wt_sel,
    output in_fwd, s_in_fwd, in_valid_fwd, psum_fwd, psum_valid
  );

endinterface

// File: rtl/fixed_sat.sv
// Clamps a wide signed sum into OUT_W bits, as a signed or unsigned range.
module fixed_sat #(
  parameter int IN_W  = 13,
  parameter int OUT_W = 11
) (
  input  logic signed [IN_W-1:0]  i_val,
  input  logic                    i_signed,
  output logic        [OUT_W-1:0] o_val
);

  localparam logic signed [IN_W-1:0] S_MAX = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] S_MIN = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [IN_W-1:0] U_MAX = {{(IN_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  // NOTE: o_val gets a default first so every path assigns it and no latch is inferred.
  always_comb begin
    o_val = i_val[OUT_W-1:0];
    if (i_signed) begin
      if (i_val > S_MAX)      o_val = {1'b0, {(OUT_W-1){1'b1}}};
      else if (i_val < S_MIN) o_val = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      if (i_val[IN_W-1])      o_val = '0;
      else if (i_val > U_MAX) o_val = '1;
    end
  end

endmodule

// File: rtl/fixed_pe_ws.sv
// Weight-stationary PE: activation x banked weight plus incoming partial sum,
// two-stage pipeline, activation forwarded to the neighbour after one cycle.
module fixed_pe_ws
  import fixed_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int WT_W      = 2,
  parameter int COL_WIDTH = 11,
  parameter int NUM_WT    = 4,
  parameter int SAT       = SAT_WRAP
) (
  input  logic          clk,
  input  logic          rst,
  fixed_pe_ws_if.slave  pe
);

  localparam int PW = IN_W + WT_W + 1;
  localparam int SW = COL_WIDTH + 2;

  wt_entry_t                   r_bank [NUM_WT];
  wt_entry_t                   w_entry;
  wt_entry_t                   w_wr_entry;
  logic signed [IN_W:0]        w_act;
  logic signed [WT_W_MAX:0]    w_wt;

  logic signed [PW-1:0]        r_prod;
  logic        [COL_WIDTH-1:0] r_psum;
  logic                        r_res_signed;
  logic                        r_v1;

  logic signed [SW-1:0]        w_prod_ext;
  logic signed [SW-1:0]        w_psum_ext;
  logic signed [SW-1:0]        w_sum;
  logic        [COL_WIDTH-1:0] w_sat;
  logic        [COL_WIDTH-1:0] w_result;

  logic        [COL_WIDTH-1:0] r_psum_fwd;
  logic                        r_psum_valid;
  logic        [IN_W-1:0]      r_in_fwd;
  logic                        r_s_in_fwd;
  logic                        r_in_valid_fwd;

  // Reading the registered bank gives the pre-write value on a same-cycle load.
  always_comb begin
    w_entry = '0;
    if (int'(pe.wt_sel) < NUM_WT) w_entry = r_bank[pe.wt_sel];
  end

  assign w_wr_entry = '{s: pe.s_weight,
                        w: pe.s_weight ? WT_W_MAX'($signed(pe.wt_data))
                                       : WT_W_MAX'(pe.wt_data)};

  assign w_act = $signed({pe.s_in & pe.in[IN_W-1], pe.in});
  assign w_wt  = $signed({w_entry.s & w_entry.w[WT_W_MAX-1], w_entry.w});

  assign w_prod_ext = SW'(r_prod);
  assign w_psum_ext = r_res_signed ? SW'($signed(r_psum)) : SW'(r_psum);
  assign w_sum      = w_prod_ext + w_psum_ext;

  fixed_sat #(
    .IN_W  (SW),
    .OUT_W (COL_WIDTH)
  ) u_sat (
    .i_val    (w_sum),
    .i_signed (r_res_signed),
    .o_val    (w_sat)
  );

  assign w_result = (SAT == SAT_CLAMP) ? w_sat : w_sum[COL_WIDTH-1:0];

  // NOTE: the weight bank is reset along with the pipeline, so every entry reads 0 after rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_WT; i++) r_bank[i] <= '0;
      r_prod         <= '0;
      r_psum         <= '0;
      r_res_signed   <= 1'b0;
      r_v1           <= 1'b0;
      r_psum_fwd     <= '0;
      r_psum_valid   <= 1'b0;
      r_in_fwd       <= '0;
      r_s_in_fwd     <= 1'b0;
      r_in_valid_fwd <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      if (pe.wt_load && int'(pe.wt_addr) < NUM_WT) r_bank[pe.wt_addr] <= w_wr_entry;

      r_in_fwd       <= pe.in;
      r_s_in_fwd     <= pe.s_in;
      r_in_valid_fwd <= pe.in_valid;

      r_v1 <= pe.in_valid;
      if (pe.in_valid) begin
        r_prod       <= PW'(w_act * w_wt);
        r_psum       <= pe.psum_in;
        r_res_signed <= pe.s_in | w_entry.s;
      end

      r_psum_valid <= r_v1;
      if (r_v1) r_psum_fwd <= w_result;
    end
  end

  assign pe.in_fwd       = r_in_fwd;
  assign pe.s_in_fwd     = r_s_in_fwd;
  assign pe.in_valid_fwd = r_in_valid_fwd;
  assign pe.psum_fwd     = r_psum_fwd;
  assign pe.psum_valid   = r_psum_valid;

endmodule

// File: tb/tb_fixed_pe_ws.sv
// Drives a wrapping and a saturating PE with identical stimulus and compares
// both against an arithmetic reference model.
module tb_fixed_pe_ws;

  localparam int IN_W   = 8;
  localparam int WT_W   = 2;
  localparam int CW     = 11;
  localparam int NUM_WT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fixed_pe_ws_if #(.IN_W(IN_W), .WT_W(WT_W), .COL_WIDTH(CW), .NUM_WT(NUM_WT)) if_w ();
  fixed_pe_ws_if #(.IN_W(IN_W), .WT_W(WT_W), .COL_WIDTH(CW), .NUM_WT(NUM_WT)) if_s ();

  fixed_pe_ws #(.IN_W(IN_W), .WT_W(WT_W), .COL_WIDTH(CW), .NUM_WT(NUM_WT), .SAT(0)) dut_w (
    .clk (clk), .rst (rst), .pe (if_w.slave));
  fixed_pe_ws #(.IN_W(IN_W), .WT_W(WT_W), .COL_WIDTH(CW), .NUM_WT(NUM_WT), .SAT(1)) dut_s (
    .clk (clk), .rst (rst), .pe (if_s.slave));

  typedef struct {
    logic          v;
    logic [CW-1:0] wrap;
    logic [CW-1:0] sat;
  } exp_t;

  int            vectors     = 0;
  int            miscompares = 0;
  logic [1:0]    m_w [NUM_WT];
  logic          m_s [NUM_WT];
  exp_t          pend [$];
  logic [CW-1:0] last_w, last_s;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic v, input logic [7:0] a, input logic sa,
                                 input logic [10:0] p, input logic [1:0] sel);
    exp_t e;
    int av, bv, pv, sum, lo, hi, cl;
    logic rs;
    av  = sa ? int'($signed(a)) : int'(a);
    bv  = m_s[sel] ? int'($signed(m_w[sel])) : int'(m_w[sel]);
    rs  = sa | m_s[sel];
    pv  = rs ? int'($signed(p)) : int'(p);
    sum = av * bv + pv;
    lo  = rs ? -(1 << (CW - 1)) : 0;
    hi  = rs ? (1 << (CW - 1)) - 1 : (1 << CW) - 1;
    cl  = (sum < lo) ? lo : ((sum > hi) ? hi : sum);
    e.v    = v;
    e.wrap = CW'(sum);
    e.sat  = CW'(cl);
    return e;
  endfunction

  task automatic drive(input logic v, input logic [7:0] a, input logic sa, input logic [10:0] p,
                       input logic [1:0] sel, input logic ld, input logic [1:0] addr,
                       input logic [1:0] d, input logic sw);
    if_w.in_valid = v;  if_w.in = a;  if_w.s_in = sa;  if_w.psum_in = p;  if_w.wt_sel = sel;
    if_w.wt_load = ld;  if_w.wt_addr = addr;  if_w.wt_data = d;  if_w.s_weight = sw;
    if_s.in_valid = v;  if_s.in = a;  if_s.s_in = sa;  if_s.psum_in = p;  if_s.wt_sel = sel;
    if_s.wt_load = ld;  if_s.wt_addr = addr;  if_s.wt_data = d;  if_s.s_weight = sw;
  endtask

  // One clock of stimulus; checks forwarding and the result of the previous step.
  task automatic step(input logic v, input logic [7:0] a, input logic sa, input logic [10:0] p,
                      input logic [1:0] sel, input logic ld = 1'b0, input logic [1:0] addr = 2'd0,
                      input logic [1:0] d = 2'd0, input logic sw = 1'b0);
    exp_t o;
    drive(v, a, sa, p, sel, ld, addr, d, sw);
    pend.push_back(model(v, a, sa, p, sel));
    if (ld) begin
      m_w[addr] = d;
      m_s[addr] = sw;
    end
    @(posedge clk);
    @(negedge clk);
    check("in_fwd", 32'(if_w.in_fwd), 32'(a));
    check("s_in_fwd", 32'(if_s.s_in_fwd), 32'(sa));
    check("in_valid_fwd", 32'(if_w.in_valid_fwd), 32'(v));
    o = pend.pop_front();
    if (o.v) begin
      last_w = o.wrap;
      last_s = o.sat;
    end
    check("psum_valid_wrap", 32'(if_w.psum_valid), 32'(o.v));
    check("psum_valid_sat", 32'(if_s.psum_valid), 32'(o.v));
    check("psum_fwd_wrap", 32'(if_w.psum_fwd), 32'(last_w));
    check("psum_fwd_sat", 32'(if_s.psum_fwd), 32'(last_s));
  endtask

  task automatic idle();
    step(1'b0, 8'd0, 1'b0, 11'd0, 2'd0);
  endtask

  // Reset with a live input and a weight load pending; both must be ignored.
  task automatic do_reset(input int n);
    rst = 1'b1;
    drive(1'b1, 8'($urandom), 1'b1, 11'($urandom), 2'd1, 1'b1, 2'd2, 2'd3, 1'b1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_psum_fwd", 32'(if_w.psum_fwd | if_s.psum_fwd), 32'd0);
      check("rst_psum_valid", 32'(if_w.psum_valid | if_s.psum_valid), 32'd0);
      check("rst_in_fwd", 32'(if_w.in_fwd | if_s.in_fwd), 32'd0);
      check("rst_fwd_flags", 32'({if_w.s_in_fwd, if_w.in_valid_fwd, if_s.s_in_fwd, if_s.in_valid_fwd}), 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < NUM_WT; i++) begin
      m_w[i] = 2'd0;
      m_s[i] = 1'b0;
    end
    pend.delete();
    pend.push_back('{v: 1'b0, wrap: '0, sat: '0});
    last_w = '0;
    last_s = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(2);
    repeat (3) idle();

    // bank[1] = -1, unsigned 5 plus 10
    step(1'b0, 8'd0, 1'b0, 11'd0, 2'd0, 1'b1, 2'd1, 2'b11, 1'b1);
    step(1'b1, 8'd5, 1'b0, 11'd10, 2'd1);
    idle();
    check("basic_wrap", 32'(if_w.psum_fwd), 32'd5);
    check("basic_valid", 32'(if_w.psum_valid), 32'd1);

    // -128 x -2
    step(1'b0, 8'd0, 1'b0, 11'd0, 2'd0, 1'b1, 2'd2, 2'b10, 1'b1);
    step(1'b1, 8'h80, 1'b1, 11'd0, 2'd2);
    idle();
    check("signed_wrap", 32'(if_w.psum_fwd), 32'd256);
    check("signed_sat", 32'(if_s.psum_fwd), 32'd256);

    // 255 x 3 + 2000 overflows 11 bits
    step(1'b0, 8'd0, 1'b0, 11'd0, 2'd0, 1'b1, 2'd3, 2'd3, 1'b0);
    step(1'b1, 8'd255, 1'b0, 11'd2000, 2'd3);
    idle();
    check("overflow_wrap", 32'(if_w.psum_fwd), 32'd717);
    check("overflow_sat", 32'(if_s.psum_fwd), 32'd2047);

    // Same-cycle load and use of bank[0]: old weight 3, then new weight 1
    step(1'b0, 8'd0, 1'b0, 11'd0, 2'd0, 1'b1, 2'd0, 2'd3, 1'b0);
    step(1'b1, 8'd4, 1'b0, 11'd0, 2'd0, 1'b1, 2'd0, 2'd1, 1'b0);
    step(1'b1, 8'd4, 1'b0, 11'd0, 2'd0);
    check("collision_old", 32'(if_w.psum_fwd), 32'd12);
    idle();
    check("collision_new", 32'(if_w.psum_fwd), 32'd4);

    // Eight back-to-back inputs across all bank entries
    for (int i = 0; i < 8; i++)
      step(1'b1, 8'($urandom), 1'($urandom), 11'($urandom), 2'(i));
    repeat (2) idle();

    // Input in flight at reset is dropped
    step(1'b1, 8'd77, 1'b0, 11'd5, 2'd3);
    do_reset(1);
    repeat (3) idle();

    for (int i = 0; i < 300; i++) begin
      logic ld;
      ld = ($urandom_range(0, 3) == 0);
      step(1'($urandom), 8'($urandom), 1'($urandom), 11'($urandom), 2'($urandom),
           ld, 2'($urandom), 2'($urandom), 1'($urandom));
    end
    repeat (2) idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fixed_pe_ws.md
FIXED_PE_WS -- requirements
Module: fixed_pe_ws

Interface
REQ-001 SHALL have parameter IN_W, default 8, activation operand width.
REQ-002 SHALL have parameter WT_W, default 2, weight operand width.
REQ-003 SHALL have parameter COL_WIDTH, default 11, partial-sum width.
REQ-004 SHALL have parameter NUM_WT, default 4, weight bank depth (>=2); AW = clog2(NUM_WT).
REQ-005 SHALL have parameter SAT, default 0: 0 = wrap result, 1 = saturate result.
REQ-006 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have ports in_valid in 1, in in IN_W, s_in in 1: activation valid, activation value, activation signed.
REQ-009 SHALL have port psum_in  in  COL_WIDTH  incoming partial sum, sampled with in_valid.
REQ-010 SHALL have ports wt_load in 1, wt_addr in AW, wt_data in WT_W, s_weight in 1: weight bank write, with per-entry signed flag.
REQ-011 SHALL have port wt_sel  in  AW  bank entry used for the current activation.
REQ-012 SHALL have ports in_fwd out IN_W, s_in_fwd out 1, in_valid_fwd out 1: activation forwarded to the neighbour PE.
REQ-013 SHALL have ports psum_fwd out COL_WIDTH, psum_valid out 1: result partial sum and its valid.

Function
REQ-014 SHALL write wt_data and s_weight into bank[wt_addr] at the edge where wt_load=1; no other entry changes.
REQ-015 SHALL use the pre-write bank value when wt_load and wt_sel target the same entry in one cycle; the new value applies from the next cycle.
REQ-016 SHALL register in, s_in and in_valid to in_fwd, s_in_fwd and in_valid_fwd with 1-cycle latency, every cycle, independent of wt_load.
REQ-017 Stage 1 (in_valid=1) SHALL register product = in x bank[wt_sel].w; each operand is sign-extended if its flag is 1, zero-extended otherwise; product is IN_W+WT_W+1 bits signed.
REQ-018 Stage 1 SHALL also register psum_in and the mode bit res_signed = s_in | bank[wt_sel].s.
REQ-019 psum_in SHALL be taken as signed when res_signed=1 and as unsigned otherwise.
REQ-020 Stage 2 SHALL form sum = product + psum_in in COL_WIDTH+2 bits signed, with no internal overflow.
REQ-021 With SAT=0, psum_fwd SHALL be sum[COL_WIDTH-1:0].
REQ-022 With SAT=1 and res_signed=1, psum_fwd SHALL be sum clamped to [-2^(COL_WIDTH-1), 2^(COL_WIDTH-1)-1].
REQ-023 With SAT=1 and res_signed=0, psum_fwd SHALL be sum clamped to [0, 2^COL_WIDTH-1].
REQ-024 psum_valid SHALL assert exactly 2 cycles after an in_valid=1 sample, one pulse per accepted input; back-to-back inputs SHALL give back-to-back outputs at full throughput.
REQ-025 psum_fwd SHALL hold its last value while psum_valid=0.

Reset
REQ-026 While rst=1 at a clock edge, psum_fwd, in_fwd, s_in_fwd, in_valid_fwd, psum_valid, all stage registers and every bank entry (value and flag) SHALL become 0.
REQ-027 rst SHALL take priority over wt_load and in_valid.
REQ-028 Inputs in flight when rst asserts SHALL be discarded; no psum_valid pulse SHALL be produced for them.

Structure
REQ-029 Shared package fixed_pkg SHALL hold the wrap/saturate mode constants and the weight entry typedef {s, w}.
REQ-030 Clamp logic SHALL be a sub-module fixed_sat (parameterised width, signed-mode input); the multiplier SHALL stay inline.

Verification
REQ-031 Reset: hold rst 2 cycles with in_valid=1 -> all outputs 0, no psum_valid for 3 cycles after release.
REQ-032 Load bank[1]=2'b11 with s_weight=1 (-1); in=5, s_in=0, wt_sel=1, psum_in=10 -> 2 cycles later psum_fwd=5, psum_valid=1.
REQ-033 Signed operands: in=8'h80 with s_in=1 (-128), weight 2'b10 with s_weight=1 (-2), psum_in=0 -> psum_fwd=256.
REQ-034 Overflow: unsigned in=255, weight=3, psum_in=2000 -> SAT=1 gives 2047; SAT=0 gives 717.
REQ-035 Write-collision: wt_load to bank[0] (3 -> 1) in the same cycle as wt_sel=0, in=4 -> result 12; next input in=4 -> result 4.
REQ-036 Streaming: 8 consecutive in_valid cycles with varying wt_sel -> 8 consecutive psum_valid cycles with matching results; in_fwd trails in by exactly 1 cycle.
